// File: rtl/control_sequencer.sv
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired fetch/decode/execute sequencer (T0..T6) driving the
//                datapath's bus selects, register enables and ALU op code.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        Cout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPc,
    output logic        read,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [3:0]  control,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t      r_state;
    logic        r_illegal;

    logic [4:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_is_hl;
    logic        w_is_un;
    logic        w_is_nop;
    logic        w_is_halt;
    logic        w_is_bad;
    logic [3:0]  w_alu;
    logic        w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_unused_ir = ^ir[14:0];

    assign w_is_r    = (w_op <= 5'd7);
    assign w_is_i    = (w_op == 5'd8) || (w_op == 5'd9) || (w_op == 5'd10);
    assign w_is_hl   = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_is_un   = (w_op == 5'd17) || (w_op == 5'd18);
    assign w_is_nop  = (w_op == 5'd24);
    assign w_is_halt = (w_op == 5'd25);
    assign w_is_bad  = !(w_is_r || w_is_i || w_is_hl || w_is_un || w_is_nop || w_is_halt);

    always_comb begin
        w_alu = 4'd0;
        case (w_op)
            5'd0, 5'd1, 5'd2, 5'd3,
            5'd4, 5'd5, 5'd6, 5'd7: w_alu = w_op[3:0];
            5'd8:                   w_alu = 4'd0;
            5'd9:                   w_alu = 4'd2;
            5'd10:                  w_alu = 4'd3;
            5'd15:                  w_alu = 4'd8;
            5'd16:                  w_alu = 4'd9;
            5'd17:                  w_alu = 4'd10;
            5'd18:                  w_alu = 4'd11;
            default:                w_alu = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RST;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_RST:  r_state <= S_T0;
                S_T0:   r_state <= S_T1;
                S_T1:   if (mem_ready) r_state <= S_T2;
                S_T2:   r_state <= S_T3;
                S_T3: begin
                    if (w_is_nop)
                        r_state <= S_T0;
                    else if (w_is_halt)
                        r_state <= S_HALT;
                    else if (w_is_bad) begin
                        r_illegal <= 1'b1;
                        r_state   <= S_HALT;
                    end else
                        r_state <= S_T4;
                end
                S_T4:   r_state <= w_is_un ? S_T0 : S_T5;
                S_T5:   r_state <= w_is_hl ? S_T6 : S_T0;
                S_T6:   r_state <= S_T0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_RST;
            endcase
        end
    end

    // Decoded from the current state so T3 sees the IR loaded at the end of T2
    // and the T1 PC update tracks mem_ready in the same cycle.
    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        Cout     = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPc    = 1'b0;
        read     = 1'b0;
        Rout     = 16'd0;
        Rin      = 16'd0;
        control  = 4'd0;
        case (r_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPc = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (w_is_r || w_is_i) begin
                    Rout = 16'd1 << w_rb;
                    Yin  = 1'b1;
                end else if (w_is_hl) begin
                    Rout = 16'd1 << w_ra;
                    Yin  = 1'b1;
                end else if (w_is_un) begin
                    Rout    = 16'd1 << w_rb;
                    control = w_alu;
                    Zin     = 1'b1;
                end
            end
            S_T4: begin
                if (w_is_un) begin
                    Zlowout = 1'b1;
                    Rin     = 16'd1 << w_ra;
                end else begin
                    if (w_is_r)
                        Rout = 16'd1 << w_rc;
                    else if (w_is_i)
                        Cout = 1'b1;
                    else
                        Rout = 16'd1 << w_rb;
                    control = w_alu;
                    Zin     = 1'b1;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_is_hl)
                    LOin = 1'b1;
                else
                    Rin  = 16'd1 << w_ra;
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Scoreboard bench; a per-instruction reference model pushes the
//                expected control word for every cycle, a monitor compares.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        mem_ready = 1'b0;
    logic        PCout, Zlowout, Zhighout, MDRout, Cout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic        IncPc, read, halted, illegal;
    logic [15:0] Rout, Rin;
    logic [3:0]  control;

    control_sequencer dut (
        .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .Cout(Cout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPc(IncPc),
        .read(read), .Rout(Rout), .Rin(Rin), .control(control),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pcout, zlowout, zhighout, mdrout, cout;
        logic        marin, zin, pcin, mdrin, irin, yin, hiin, loin;
        logic        incpc, read;
        logic [15:0] rout, rin;
        logic [3:0]  control;
        logic        halted, illegal;
    } ctl_t;

    typedef struct {
        ctl_t  e;
        string nm;
    } item_t;

    item_t       sb[$];
    item_t       mon_it;
    ctl_t        act;
    logic [31:0] cur_ir = 32'd0;
    int          checks = 0;
    int          errors = 0;
    int          legal_ops[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15, 16, 17, 18, 24};
    int          bad_ops[17]   = '{11, 12, 13, 14, 19, 20, 21, 22, 23, 26, 27, 28, 29, 30, 31, 11, 31};

    assign act = {PCout, Zlowout, Zhighout, MDRout, Cout,
                  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
                  IncPc, read, Rout, Rin, control, halted, illegal};

    task automatic check(input string nm, input ctl_t a, input ctl_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_it = sb.pop_front();
                check(mon_it.nm, act, mon_it.e);
            end
        end
    end

    // One clock cycle of stimulus; e is what the outputs must be during it.
    task automatic cycle(input ctl_t e, input string nm, input logic mr, input logic rst_v);
        item_t it;
        @(posedge clk);
        #1;
        reset     = rst_v;
        mem_ready = mr;
        ir        = cur_ir;
        it.e  = e;
        it.nm = nm;
        sb.push_back(it);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 R, 1 I, 2 mul/div, 3 unary, 4 nop, 5 halt, 6 illegal
    function automatic int op_class(input int op);
        if (op <= 7)               return 0;
        if (op >= 8 && op <= 10)   return 1;
        if (op == 15 || op == 16)  return 2;
        if (op == 17 || op == 18)  return 3;
        if (op == 24)              return 4;
        if (op == 25)              return 5;
        return 6;
    endfunction

    function automatic logic [3:0] alu_of(input int op);
        case (op)
            8:  return 4'd0;
            9:  return 4'd2;
            10: return 4'd3;
            15: return 4'd8;
            16: return 4'd9;
            17: return 4'd10;
            18: return 4'd11;
            default: return (op <= 7) ? 4'(op) : 4'd0;
        endcase
    endfunction

    task automatic reset_pulse(input string tag);
        ctl_t z;
        z = '0;
        cycle(z, {tag, "_rst"}, rnd(), 1'b0);
        cycle(z, {tag, "_rel"}, rnd(), 1'b1);
    endtask

    task automatic run_instr(input int op, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [3:0] rc, input int nwait, input bit abort);
        ctl_t e;
        ctl_t steps[$];
        int   cls;
        cls = op_class(op);

        e = '0; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
        cycle(e, "T0", rnd(), 1'b1);
        for (int w = 0; w < nwait; w++) begin
            e = '0; e.read = 1; e.mdrin = 1;
            cycle(e, "T1_wait", 1'b0, 1'b1);
        end
        e = '0; e.read = 1; e.mdrin = 1; e.zlowout = 1; e.pcin = 1;
        cycle(e, "T1_ready", 1'b1, 1'b1);
        e = '0; e.mdrout = 1; e.irin = 1;
        cycle(e, "T2", rnd(), 1'b1);
        cur_ir = {5'(op), ra, rb, rc, 15'($urandom)};

        case (cls)
            0, 1: begin
                e = '0; e.rout = 16'd1 << rb; e.yin = 1; steps.push_back(e);
                e = '0; e.control = alu_of(op); e.zin = 1;
                if (cls == 0) e.rout = 16'd1 << rc; else e.cout = 1;
                steps.push_back(e);
                e = '0; e.zlowout = 1; e.rin = 16'd1 << ra; steps.push_back(e);
            end
            2: begin
                e = '0; e.rout = 16'd1 << ra; e.yin = 1; steps.push_back(e);
                e = '0; e.rout = 16'd1 << rb; e.control = alu_of(op); e.zin = 1; steps.push_back(e);
                e = '0; e.zlowout = 1; e.loin = 1; steps.push_back(e);
                e = '0; e.zhighout = 1; e.hiin = 1; steps.push_back(e);
            end
            3: begin
                e = '0; e.rout = 16'd1 << rb; e.control = alu_of(op); e.zin = 1; steps.push_back(e);
                e = '0; e.zlowout = 1; e.rin = 16'd1 << ra; steps.push_back(e);
            end
            default: begin
                e = '0; steps.push_back(e);
            end
        endcase

        for (int k = 0; k < steps.size(); k++) begin
            cycle(steps[k], $sformatf("op%0d_T%0d", op, k + 3), rnd(), 1'b1);
            if (abort && k == 1) begin
                @(negedge clk);
                #1;
                reset = 1'b0;
                #1;
                check("async_reset_T4", act, ctl_t'('0));
                e = '0;
                cycle(e, "abort_hold", rnd(), 1'b0);
                cycle(e, "abort_rel", rnd(), 1'b1);
                return;
            end
        end

        if (cls == 5 || cls == 6) begin
            for (int h = 0; h < 3; h++) begin
                e = '0; e.halted = 1; e.illegal = (cls == 6);
                cycle(e, (cls == 6) ? "illegal_halt" : "halt", rnd(), 1'b1);
            end
            reset_pulse("halt");
        end
    endtask

    initial begin
        ctl_t z;
        int   op;
        int   sel;
        int   cls;
        z = '0;
        cycle(z, "reset0", 1'b0, 1'b0);
        cycle(z, "reset1", 1'b1, 1'b0);
        cycle(z, "reset_rel", 1'b1, 1'b1);

        run_instr(0, 4'd3, 4'd1, 4'd2, 0, 1'b0);
        run_instr(8, 4'd4, 4'd4, 4'd0, 0, 1'b0);
        run_instr(15, 4'd6, 4'd7, 4'd0, 0, 1'b0);
        run_instr(1, 4'd9, 4'd2, 4'd15, 3, 1'b0);
        run_instr(17, 4'd0, 4'd15, 4'd5, 1, 1'b0);
        run_instr(24, 4'd1, 4'd1, 4'd1, 0, 1'b0);
        run_instr(31, 4'd2, 4'd3, 4'd4, 0, 1'b0);
        run_instr(25, 4'd0, 4'd0, 4'd0, 2, 1'b0);
        run_instr(0, 4'd3, 4'd1, 4'd2, 0, 1'b1);

        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0)
                op = 25;
            else if (sel == 1)
                op = bad_ops[$urandom_range(0, 16)];
            else
                op = legal_ops[$urandom_range(0, 15)];
            cls = op_class(op);
            run_instr(op, 4'($urandom), 4'($urandom), 4'($urandom),
                      $urandom_range(0, 3),
                      (cls <= 3) && ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
